// File: rtl/wb_stage_skid_pkg.sv
// Shared constants and lane record for the MEM->WB write-back path.
package wb_stage_skid_pkg;

  localparam logic FALSE = 1'b0;
  localparam logic TRUE  = 1'b1;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [REG_DATA_W-1:0] ZERO_WORD  = '0;
  localparam logic [REG_ADDR_W-1:0] RegAddrNOP = '0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } wb_lane_t;

  function automatic logic [31:0] popcount32(input logic [31:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry ready/valid skid buffer; in_ready depends only on registered occupancy.
//   state    | meaning
//   ST_EMPTY | main and skid invalid
//   ST_ONE   | main valid, skid invalid
//   ST_TWO   | main and skid valid
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  import wb_stage_skid_pkg::*;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_ready  = rdy & ~rst & (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready & rdy;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (rdy == TRUE) begin
      if (flush) begin
        // Payload is left stale; out_valid gates everything downstream.
        state_d = ST_EMPTY;
      end else begin
        case (state_q)
          ST_EMPTY: if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
          ST_ONE: begin
            if (in_fire && out_fire) begin
              main_d = in_data;
            end else if (in_fire) begin
              skid_d  = in_data;
              state_d = ST_TWO;
            end else if (out_fire) begin
              state_d = ST_EMPTY;
            end
          end
          ST_TWO: if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/wb_stage_skid.sv
// MEM->WB stage register: NUM_LANES write-back lanes through a 2-entry skid buffer.
// Define WB_STAGE_PERF_EN to add the perf_retired / perf_backpressure counters.
module wb_stage_skid
  import wb_stage_skid_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DROP_X0   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES-1:0]        in_we,
  input  logic [NUM_LANES*ADDR_W-1:0] in_dest,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_we,
  output logic [NUM_LANES*ADDR_W-1:0] out_dest,
  output logic [NUM_LANES*DATA_W-1:0] out_data
`ifdef WB_STAGE_PERF_EN
  ,
  output logic [31:0]                 perf_retired,
  output logic [31:0]                 perf_backpressure
`endif
);

  localparam int PW = NUM_LANES * (1 + ADDR_W + DATA_W);

  logic [NUM_LANES-1:0] cap_we;
  logic [PW-1:0]        cap_payload;
  logic [PW-1:0]        head_payload;
  logic [NUM_LANES-1:0] head_we;

  // Writes to x0 are squashed once at capture so the regfile never sees them.
  always_comb begin
    cap_we = in_we;
    if (DROP_X0 != 0) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        cap_we[i] = in_we[i] & (in_dest[i*ADDR_W +: ADDR_W] != '0);
      end
    end
  end

  assign cap_payload = {cap_we, in_dest, in_data};

  skid_buf2 #(
    .W(PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (cap_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_payload)
  );

  assign head_we  = head_payload[PW-1 -: NUM_LANES];
  assign out_we   = head_we & {NUM_LANES{out_valid}};
  assign out_dest = head_payload[NUM_LANES*DATA_W +: NUM_LANES*ADDR_W];
  assign out_data = head_payload[0 +: NUM_LANES*DATA_W];

`ifdef WB_STAGE_PERF_EN
  logic [31:0] perf_retired_q, perf_retired_d;
  logic [31:0] perf_backpressure_q, perf_backpressure_d;

  always_comb begin
    perf_retired_d      = perf_retired_q;
    perf_backpressure_d = perf_backpressure_q;
    if (rdy) begin
      if (out_valid && out_ready) begin
        perf_retired_d = perf_retired_q + popcount32(32'(out_we));
      end
      if (out_valid && !out_ready) begin
        perf_backpressure_d = perf_backpressure_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired_q      <= '0;
      perf_backpressure_q <= '0;
    end else begin
      perf_retired_q      <= perf_retired_d;
      perf_backpressure_q <= perf_backpressure_d;
    end
  end

  assign perf_retired      = perf_retired_q;
  assign perf_backpressure = perf_backpressure_q;
`endif

endmodule

// File: tb/tb_wb_stage_skid.sv
// Directed vector bench for wb_stage_skid (2 lanes), with x0-drop and x0-keep instances.
module tb_wb_stage_skid;

  localparam int NL = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, rdy, flush, in_valid, out_ready;
  logic [NL-1:0]      in_we;
  logic [NL*AW-1:0]   in_dest;
  logic [NL*DW-1:0]   in_data;
  logic               in_ready, out_valid, k_in_ready, k_out_valid;
  logic [NL-1:0]      out_we, k_out_we;
  logic [NL*AW-1:0]   out_dest, k_out_dest;
  logic [NL*DW-1:0]   out_data, k_out_data;
`ifdef WB_STAGE_PERF_EN
  logic [31:0] perf_retired, perf_backpressure, k_perf_retired, k_perf_backpressure;
`endif

  wb_stage_skid #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .DROP_X0(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_dest(in_dest), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_we(out_we), .out_dest(out_dest), .out_data(out_data)
`ifdef WB_STAGE_PERF_EN
    , .perf_retired(perf_retired), .perf_backpressure(perf_backpressure)
`endif
  );

  wb_stage_skid #(.NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .DROP_X0(0)) dut_keep (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(k_in_ready),
    .in_we(in_we), .in_dest(in_dest), .in_data(in_data),
    .out_valid(k_out_valid), .out_ready(out_ready),
    .out_we(k_out_we), .out_dest(k_out_dest), .out_data(k_out_data)
`ifdef WB_STAGE_PERF_EN
    , .perf_retired(k_perf_retired), .perf_backpressure(k_perf_backpressure)
`endif
  );

  typedef struct {
    logic       rst, rdy, flush, iv;
    int         in_id;
    logic       ordy;
    logic       e_ir, e_ov;
    int         e_id;
    logic [1:0] e_we, e_wek;
  } vec_t;

  vec_t        vecs[$];
  logic [1:0]  ent_we[16];
  logic [9:0]  ent_dest[16];
  logic [63:0] ent_data[16];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic vec_t mk(logic r, logic y, logic f, logic v, int iid, logic o,
                              logic eir, logic eov, int eid, logic [1:0] ew, logic [1:0] ewk);
    vec_t t;
    t.rst = r; t.rdy = y; t.flush = f; t.iv = v; t.in_id = iid; t.ordy = o;
    t.e_ir = eir; t.e_ov = eov; t.e_id = eid; t.e_we = ew; t.e_wek = ewk;
    return t;
  endfunction

  task automatic chk(string name, int row, logic [63:0] got, logic [63:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %h want %h", row, name, got, exp);
    end
  endtask

  task automatic drive(logic r, logic y, logic f, logic v, int id, logic o);
    @(negedge clk);
    rst = r; rdy = y; flush = f; in_valid = v; out_ready = o;
    in_we = ent_we[id]; in_dest = ent_dest[id]; in_data = ent_data[id];
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_we = '0; in_dest = '0; in_data = '0;

    ent_we[0] = 2'b00; ent_dest[0] = '0; ent_data[0] = '0;
    for (int k = 1; k < 16; k++) begin
      ent_we[k]   = 2'b11;
      ent_dest[k] = {5'(k + 5), 5'(k + 4)};
      ent_data[k] = {32'(k) * 32'h22, 32'(k) * 32'h11};
    end
    ent_dest[8] = {5'd3, 5'd0};
    ent_data[8] = {32'h0000_BEEF, 32'h0000_DEAD};

    //              rst rdy fl iv  in  ordy  ir  ov  id  we     wek
    vecs.push_back(mk(1, 1, 0, 0,  0, 1,    0,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 1,  1, 1,    1,  1,  1, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  2, 1,    1,  1,  2, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  3, 1,    1,  1,  3, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  4, 1,    1,  1,  4, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1,    1,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 1,  5, 0,    1,  1,  5, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  6, 0,    0,  1,  5, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  7, 0,    0,  1,  5, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  7, 0,    0,  1,  5, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  7, 1,    1,  1,  6, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  7, 1,    1,  1,  7, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1,    1,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 1,  8, 0,    1,  1,  8, 2'b10, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1,  9, 0,    0,  1,  8, 2'b10, 2'b11));
    vecs.push_back(mk(0, 1, 1, 1, 10, 0,    1,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1,    1,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 1, 11, 0,    1,  1, 11, 2'b11, 2'b11));
    vecs.push_back(mk(0, 0, 0, 1, 12, 1,    0,  1, 11, 2'b11, 2'b11));
    vecs.push_back(mk(0, 0, 0, 1, 12, 1,    0,  1, 11, 2'b11, 2'b11));
    vecs.push_back(mk(0, 0, 0, 1, 12, 1,    0,  1, 11, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1, 12, 1,    1,  1, 12, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 1, 1, 13, 1,    1,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1,    1,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 1, 14, 0,    1,  1, 14, 2'b11, 2'b11));
    vecs.push_back(mk(0, 1, 0, 1, 15, 0,    0,  1, 14, 2'b11, 2'b11));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0,    0,  0,  0, 2'b00, 2'b00));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1,    1,  0,  0, 2'b00, 2'b00));

    for (int r = 0; r < vecs.size(); r++) begin
      drive(vecs[r].rst, vecs[r].rdy, vecs[r].flush, vecs[r].iv, vecs[r].in_id, vecs[r].ordy);
      n_vec++;
      chk("in_ready",  r, 64'(in_ready),  64'(vecs[r].e_ir));
      chk("out_valid", r, 64'(out_valid), 64'(vecs[r].e_ov));
      chk("out_we",    r, 64'(out_we),    64'(vecs[r].e_we));
      chk("keep_we",   r, 64'(k_out_we),  64'(vecs[r].e_wek));
      if (vecs[r].e_ov || vecs[r].rst) begin
        chk("out_dest", r, 64'(out_dest), 64'(ent_dest[vecs[r].e_id]));
        chk("out_data", r, out_data,      ent_data[vecs[r].e_id]);
      end
    end

`ifdef WB_STAGE_PERF_EN
    drive(1, 1, 0, 0, 0, 0);
    n_vec++;
    chk("perf_retired_rst", 100, 64'(perf_retired), 64'd0);
    chk("perf_bp_rst",      100, 64'(perf_backpressure), 64'd0);
    drive(0, 1, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 1, 2, 1);
    drive(0, 1, 0, 1, 3, 1);
    drive(0, 1, 0, 0, 0, 1);
    n_vec++;
    chk("perf_retired", 101, 64'(perf_retired), 64'd6);
    chk("perf_bp",      101, 64'(perf_backpressure), 64'd4);
    drive(1, 1, 0, 0, 0, 1);
    n_vec++;
    chk("perf_retired_clr", 102, 64'(perf_retired), 64'd0);
    chk("perf_bp_clr",      102, 64'(perf_backpressure), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
